onehot_decoder_pipe: RTL

//  Parametrised, pipelined binary-to-one-hot decoder with valid/ready flow control.

---
 rtl/onehot_decoder_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/onehot_decoder_pipe.sv
// Pipelined binary-to-one-hot decoder with valid/ready handshake and a 2-entry skid buffer.
// Optional ZERO_SEL_MASK_EN: in_sel==0 decodes to an all-zero vector (no write to register 0).
module onehot_decoder_pipe #(
  parameter int SEL_W = 5,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_range_err
);

  localparam int unsigned OUT_WU = OUT_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] dec_vec, main_vec_nxt, skid_vec, skid_vec_nxt;
  logic             dec_err, main_err_nxt, skid_err, skid_err_nxt;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Out-of-range selects give an empty vector plus an error flag rather than saturating.
  always_comb begin
    dec_vec = '0;
    dec_err = 1'b0;
    if (in_en) begin
      if (32'(in_sel) < OUT_WU) begin
        dec_vec = {{(OUT_W-1){1'b0}}, 1'b1} << in_sel;
      end else begin
        dec_err = 1'b1;
      end
    end
`ifdef ZERO_SEL_MASK_EN
    if (in_sel == '0) begin
      dec_vec = '0;
    end
`else
`endif
  end

  always_comb begin
    state_nxt    = state;
    main_vec_nxt = out_onehot;
    main_err_nxt = out_range_err;
    skid_vec_nxt = skid_vec;
    skid_err_nxt = skid_err;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt    = ONE;
          main_vec_nxt = dec_vec;
          main_err_nxt = dec_err;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_vec_nxt = dec_vec;
          main_err_nxt = dec_err;
        end else if (in_xfer) begin
          state_nxt    = FULL;
          skid_vec_nxt = dec_vec;
          skid_err_nxt = dec_err;
        end else if (out_xfer) begin
          // Outputs read as zero whenever nothing is valid.
          state_nxt    = EMPTY;
          main_vec_nxt = '0;
          main_err_nxt = 1'b0;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt    = ONE;
          main_vec_nxt = skid_vec;
          main_err_nxt = skid_err;
          skid_vec_nxt = '0;
          skid_err_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = EMPTY;
        main_vec_nxt = '0;
        main_err_nxt = 1'b0;
        skid_vec_nxt = '0;
        skid_err_nxt = 1'b0;
      end
    endcase
  end

  // Handshake outputs are flops fed from next-state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_onehot    <= '0;
      out_range_err <= 1'b0;
      skid_vec      <= '0;
      skid_err      <= 1'b0;
    end else begin
      state         <= state_nxt;
      in_ready      <= (state_nxt != FULL);
      out_valid     <= (state_nxt != EMPTY);
      out_onehot    <= main_vec_nxt;
      out_range_err <= main_err_nxt;
      skid_vec      <= skid_vec_nxt;
      skid_err      <= skid_err_nxt;
    end
  end

endmodule
